// File: rtl/rule_unpacker_512_32.sv
// Unpacks 32-lane rule-ID beats into a 2-ID-per-beat stream, dropping zero IDs
// and closing every packet with an all-zero eop terminator beat.
module rule_unpacker_512_32 #(
  parameter int unsigned RULE_WIDTH  = 16,
  parameter int unsigned IN_LANES    = 32,
  parameter int unsigned EMPTY_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RULE_WIDTH*IN_LANES-1:0] in_rule_data,
  input  logic                           in_rule_valid,
  input  logic                           in_rule_sop,
  input  logic                           in_rule_eop,
  input  logic [EMPTY_WIDTH-1:0]         in_rule_empty,
  output logic                           in_rule_ready,
  output logic [2*RULE_WIDTH-1:0]        out_rule_data,
  output logic                           out_rule_valid,
  output logic                           out_rule_sop,
  output logic                           out_rule_eop,
  input  logic                           out_rule_ready
);

  localparam int unsigned IN_BYTES   = (RULE_WIDTH * IN_LANES) / 8;
  localparam int unsigned RULE_BYTES = RULE_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(IN_LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    TERM   = 2'd2
  } state_e;

  state_e                               state_q, state_d;
  logic [IN_LANES-1:0][RULE_WIDTH-1:0]  buf_q, buf_d;
  logic [IN_LANES-1:0]                  mask_q, mask_d;
  logic                                 buf_eop_q, buf_eop_d;
  logic [RULE_WIDTH-1:0]                carry_q, carry_d;
  logic                                 carry_valid_q, carry_valid_d;
  logic                                 first_out_q, first_out_d;

  logic [IN_LANES-1:0]                  in_mask;
  logic [31:0]                          valid_bytes;
  logic                                 found0, found1;
  logic [IDX_W-1:0]                     idx0, idx1;
  logic [RULE_WIDTH-1:0]                src0, src1;
  logic                                 avail2, avail1;
  logic                                 ready_o, valid_o, eop_o;
  logic [2*RULE_WIDTH-1:0]              data_o;

  // Lane mask for an incoming beat: only lanes inside the byte count and non-zero.
  always_comb begin
    in_mask     = '0;
    valid_bytes = IN_BYTES - 32'(in_rule_empty);
    for (int unsigned i = 0; i < IN_LANES; i++) begin
      in_mask[i] = (!in_rule_eop || ((i + 1) * RULE_BYTES <= valid_bytes)) &&
                   (in_rule_data[i*RULE_WIDTH +: RULE_WIDTH] != '0);
    end
  end

  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    idx0   = '0;
    idx1   = '0;
    for (int unsigned i = 0; i < IN_LANES; i++) begin
      if (mask_q[i]) begin
        if (!found0) begin
          found0 = 1'b1;
          idx0   = IDX_W'(i);
        end else if (!found1) begin
          found1 = 1'b1;
          idx1   = IDX_W'(i);
        end
      end
    end
  end

  // Carry always precedes the buffer lanes, so it shifts the source selection by one.
  assign src0   = carry_valid_q ? carry_q : buf_q[idx0];
  assign src1   = carry_valid_q ? buf_q[idx0] : buf_q[idx1];
  assign avail2 = carry_valid_q ? found0 : found1;
  assign avail1 = !avail2 && (carry_valid_q || found0);

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    mask_d        = mask_q;
    buf_eop_d     = buf_eop_q;
    carry_d       = carry_q;
    carry_valid_d = carry_valid_q;
    first_out_d   = first_out_q;
    ready_o       = 1'b0;
    valid_o       = 1'b0;
    eop_o         = 1'b0;
    data_o        = '0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (in_rule_valid) begin
          buf_d     = in_rule_data;
          mask_d    = in_mask;
          buf_eop_d = in_rule_eop;
          state_d   = UNPACK;
          if (in_rule_sop && carry_valid_q) begin
            carry_valid_d = 1'b0;
          end
        end
      end
      UNPACK: begin
        if (avail2) begin
          valid_o = 1'b1;
          data_o  = {src1, src0};
          if (out_rule_ready) begin
            first_out_d  = 1'b0;
            mask_d[idx0] = 1'b0;
            if (carry_valid_q) begin
              carry_valid_d = 1'b0;
            end else begin
              mask_d[idx1] = 1'b0;
            end
          end
        end else if (avail1) begin
          if (buf_eop_q) begin
            valid_o = 1'b1;
            data_o  = {{RULE_WIDTH{1'b0}}, src0};
            if (out_rule_ready) begin
              first_out_d   = 1'b0;
              carry_valid_d = 1'b0;
              mask_d[idx0]  = 1'b0;
              state_d       = TERM;
            end
          end else begin
            carry_d       = src0;
            carry_valid_d = 1'b1;
            mask_d[idx0]  = 1'b0;
            state_d       = IDLE;
          end
        end else begin
          state_d = buf_eop_q ? TERM : IDLE;
        end
      end
      TERM: begin
        valid_o = 1'b1;
        eop_o   = 1'b1;
        if (out_rule_ready) begin
          first_out_d   = 1'b1;
          carry_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      mask_q        <= '0;
      buf_eop_q     <= 1'b0;
      carry_q       <= '0;
      carry_valid_q <= 1'b0;
      first_out_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      mask_q        <= mask_d;
      buf_eop_q     <= buf_eop_d;
      carry_q       <= carry_d;
      carry_valid_q <= carry_valid_d;
      first_out_q   <= first_out_d;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign in_rule_ready  = rst & ready_o;
  assign out_rule_valid = rst & valid_o;
  assign out_rule_eop   = rst & eop_o;
  assign out_rule_sop   = rst & valid_o & first_out_q;
  assign out_rule_data  = rst ? data_o : '0;

endmodule

// File: tb/tb_rule_unpacker_512_32.sv
// Self-checking bench for rule_unpacker_512_32: constant vectors, hand sequences
// and random packets checked against a packet-level reference model.
module tb_rule_unpacker_512_32;
  localparam int unsigned RW = 16;
  localparam int unsigned NL = 32;
  localparam int unsigned EW = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [RW*NL-1:0] in_rule_data = '0;
  logic             in_rule_valid = 1'b0;
  logic             in_rule_sop = 1'b0;
  logic             in_rule_eop = 1'b0;
  logic [EW-1:0]    in_rule_empty = '0;
  logic             in_rule_ready;
  logic [2*RW-1:0]  out_rule_data;
  logic             out_rule_valid;
  logic             out_rule_sop;
  logic             out_rule_eop;
  logic             out_rule_ready;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int unsigned base = 0;

  logic [33:0]  got[$];
  logic [33:0]  expq[$];
  logic [511:0] pkt_data[4];
  logic [5:0]   pkt_empty;

  typedef struct {
    logic [511:0]      data;
    logic [5:0]        empty;
    int unsigned       n;
    logic [2:0][33:0]  exp;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  rule_unpacker_512_32 #(.RULE_WIDTH(RW), .IN_LANES(NL), .EMPTY_WIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .in_rule_data(in_rule_data), .in_rule_valid(in_rule_valid),
    .in_rule_sop(in_rule_sop), .in_rule_eop(in_rule_eop),
    .in_rule_empty(in_rule_empty), .in_rule_ready(in_rule_ready),
    .out_rule_data(out_rule_data), .out_rule_valid(out_rule_valid),
    .out_rule_sop(out_rule_sop), .out_rule_eop(out_rule_eop),
    .out_rule_ready(out_rule_ready)
  );

  function automatic logic [511:0] set_lane(input logic [511:0] d, input int unsigned l,
                                            input logic [15:0] v);
    logic [511:0] r;
    r = d;
    r[l*16 +: 16] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ready_loop();
    out_ready_init: out_rule_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_rule_ready = 1'b1;
        1:       out_rule_ready = 1'b0;
        default: out_rule_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic monitor_loop();
    logic        hold = 1'b0;
    logic [33:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (out_rule_valid) begin
          chk("in_ready_while_out_valid", 64'(in_rule_ready), 64'd0);
        end
        if (hold) begin
          chk("stall_valid", 64'(out_rule_valid), 64'd1);
          chk("stall_stable", 64'({out_rule_sop, out_rule_eop, out_rule_data}), 64'(held));
        end
        hold = out_rule_valid && !out_rule_ready;
        held = {out_rule_sop, out_rule_eop, out_rule_data};
        if (out_rule_valid && out_rule_ready) begin
          got.push_back({out_rule_sop, out_rule_eop, out_rule_data});
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [511:0] d, input logic s, input logic e,
                           input logic [5:0] emp);
    int unsigned n = 0;
    in_rule_data  = d;
    in_rule_sop   = s;
    in_rule_eop   = e;
    in_rule_empty = emp;
    in_rule_valid = 1'b1;
    @(negedge clk);
    while (!in_rule_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_rule_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_rule_valid = 1'b0;
    in_rule_sop   = 1'b0;
    in_rule_eop   = 1'b0;
  endtask

  task automatic send_packet(input int unsigned nb);
    for (int unsigned b = 0; b < nb; b++) begin
      send_beat(pkt_data[b], b == 0, b == nb - 1, (b == nb - 1) ? pkt_empty : 6'd0);
    end
  endtask

  // Reference: collect the valid non-zero IDs in order, pair them, add the terminator.
  task automatic model_packet(input int unsigned nb);
    logic [15:0] ids[$];
    int unsigned nl;
    logic [15:0] id;
    logic [15:0] hi;
    expq.delete();
    for (int unsigned b = 0; b < nb; b++) begin
      nl = (b == nb - 1) ? (64 - 32'(pkt_empty)) / 2 : 32;
      for (int unsigned l = 0; l < nl; l++) begin
        id = pkt_data[b][l*16 +: 16];
        if (id != 0) ids.push_back(id);
      end
    end
    for (int unsigned i = 0; i < ids.size(); i += 2) begin
      hi = (i + 1 < ids.size()) ? ids[i+1] : 16'd0;
      expq.push_back({i == 0, 1'b0, hi, ids[i]});
    end
    expq.push_back({ids.size() == 0, 1'b1, 32'd0});
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check_packet(input string name);
    int unsigned idx = 0;
    int unsigned scan = base;
    logic        seen = 1'b0;
    int unsigned n_got;
    for (int unsigned c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk);
      while (scan < got.size() && !seen) begin
        if (got[scan][32]) begin
          seen = 1'b1;
          idx  = scan;
        end
        scan++;
      end
    end
    #1;
    if (!seen) begin
      chk({name, "_eop_timeout"}, 64'd0, 64'd1);
      finish_run();
    end
    n_got = idx - base + 1;
    chk({name, "_beats"}, 64'(n_got), 64'(expq.size()));
    for (int unsigned i = 0; i < n_got && i < expq.size(); i++) begin
      chk($sformatf("%s_beat%0d", name, i), 64'(got[base+i]), 64'(expq[i]));
    end
    base = idx + 1;
  endtask

  initial begin
    logic [511:0] d;
    int unsigned  nb;
    fork
      ready_loop();
      monitor_loop();
    join_none

    // Constant vectors: single eop beats.
    d = '0; d = set_lane(d, 0, 16'd5); d = set_lane(d, 1, 16'd7); d = set_lane(d, 2, 16'd9);
    tbl[0] = '{data: d, empty: 6'd58, n: 3,
               exp: {{1'b0, 1'b1, 32'h0}, {1'b0, 1'b0, 32'h0000_0009}, {1'b1, 1'b0, 32'h0007_0005}}};
    tbl[1] = '{data: '0, empty: 6'd0, n: 1,
               exp: {34'h0, 34'h0, {1'b1, 1'b1, 32'h0}}};
    d = '0; d = set_lane(d, 0, 16'h0101); d = set_lane(d, 3, 16'h0202); d = set_lane(d, 4, 16'h0303);
    tbl[2] = '{data: d, empty: 6'd56, n: 2,
               exp: {34'h0, {1'b0, 1'b1, 32'h0}, {1'b1, 1'b0, 32'h0202_0101}}};
    d = '0; d = set_lane(d, 0, 16'h0011); d = set_lane(d, 1, 16'h0022); d = set_lane(d, 5, 16'h0033);
    tbl[3] = '{data: d, empty: 6'd62, n: 2,
               exp: {34'h0, {1'b0, 1'b1, 32'h0}, {1'b1, 1'b0, 32'h0000_0011}}};
    d = '0; d = set_lane(d, 31, 16'hBEEF);
    tbl[4] = '{data: d, empty: 6'd0, n: 2,
               exp: {34'h0, {1'b0, 1'b1, 32'h0}, {1'b1, 1'b0, 32'h0000_BEEF}}};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_rule_ready), 64'd0);
    chk("rst_out_valid", 64'(out_rule_valid), 64'd0);
    chk("rst_out_data", 64'(out_rule_data), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", 64'(out_rule_valid), 64'd0);
    chk("idle_in_ready", 64'(in_rule_ready), 64'd1);
    @(posedge clk); #1;

    for (int unsigned t = 0; t < 5; t++) begin
      expq.delete();
      for (int unsigned i = 0; i < tbl[t].n; i++) expq.push_back(tbl[t].exp[i]);
      send_beat(tbl[t].data, 1'b1, 1'b1, tbl[t].empty);
      check_packet($sformatf("vec%0d", t));
    end

    // Carry across beats.
    pkt_data[0] = set_lane('0, 31, 16'd12);
    pkt_data[1] = set_lane('0, 0, 16'd13);
    pkt_empty = 6'd62;
    expq.delete();
    expq.push_back({1'b1, 1'b0, 32'h000D_000C});
    expq.push_back({1'b0, 1'b1, 32'h0});
    send_packet(2);
    check_packet("carry");

    // Backpressure mid-stream: 32 + 8 IDs, lanes past the byte count hold junk.
    pkt_data[0] = '0;
    pkt_data[1] = '0;
    for (int unsigned l = 0; l < 32; l++) begin
      pkt_data[0] = set_lane(pkt_data[0], l, 16'(32'h100 + l));
      pkt_data[1] = set_lane(pkt_data[1], l, 16'(32'h200 + l));
    end
    pkt_empty = 6'd48;
    model_packet(2);
    chk("bp_model_beats", 64'(expq.size()), 64'd21);
    fork
      send_packet(2);
      begin
        repeat (8) @(posedge clk);
        #1 rdy_mode = 1;
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    check_packet("bp");

    // Reset pulse while unpacking a stalled beat.
    rdy_mode = 1;
    @(posedge clk); #1;
    d = '0;
    for (int unsigned l = 0; l < 32; l++) d = set_lane(d, l, 16'(32'h300 + l));
    send_beat(d, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_rule_valid), 64'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_rule_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_rule_valid), 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("post_rst_out", 64'({out_rule_valid, out_rule_sop, out_rule_eop, out_rule_data}), 64'd0);
    base = got.size();
    rdy_mode = 0;
    @(posedge clk); #1;
    d = '0; d = set_lane(d, 0, 16'h0021); d = set_lane(d, 1, 16'h0022);
    expq.delete();
    expq.push_back({1'b1, 1'b0, 32'h0022_0021});
    expq.push_back({1'b0, 1'b1, 32'h0});
    send_beat(d, 1'b1, 1'b1, 6'd60);
    check_packet("after_rst");

    // Random packets with random downstream backpressure.
    rdy_mode = 2;
    for (int p = 0; p < 30; p++) begin
      nb = $urandom_range(1, 3);
      for (int unsigned b = 0; b < nb; b++) begin
        pkt_data[b] = '0;
        for (int unsigned l = 0; l < 32; l++) begin
          if ($urandom_range(0, 2) == 0)
            pkt_data[b] = set_lane(pkt_data[b], l, 16'($urandom_range(1, 65535)));
        end
      end
      pkt_empty = 6'(2 * $urandom_range(0, 31));
      model_packet(nb);
      send_packet(nb);
      check_packet($sformatf("rand%0d", p));
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    finish_run();
  end
endmodule
